// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RV32I decode stage with regfile, control/immediate decode, hazard stall and ID/EX register
module decode_stage_pipe #(
  parameter int WIDTH = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr_D,
  input  logic [WIDTH-1:0] pc_D,
  input  logic             valid_D,
  input  logic             flush_E,
  input  logic             regWrite_W,
  input  logic [4:0]       Rd_W,
  input  logic [WIDTH-1:0] result_W,
  output logic             stall_D,
  output logic             regWrite_E,
  output logic             memWrite_E,
  output logic             branch_E,
  output logic             jump_E,
  output logic             jalr_E,
  output logic             ALUsrc_E,
  output logic             illegal_E,
  output logic [1:0]       resultSrc_E,
  output logic [3:0]       ALUctrl_E,
  output logic [2:0]       funct3_E,
  output logic [4:0]       Rs1_E,
  output logic [4:0]       Rs2_E,
  output logic [4:0]       Rd_E,
  output logic [WIDTH-1:0] RD1_E,
  output logic [WIDTH-1:0] RD2_E,
  output logic [WIDTH-1:0] ImmExt_E,
  output logic [WIDTH-1:0] pc_E,
  output logic [WIDTH-1:0] a0
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4,
                         SLT = 4'h5, SLTU = 4'h6, SLL = 4'h7, SRL = 4'h8, SRA = 4'h9, PASS_B = 4'hF;
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic known, uses_rd, uses_rs1, uses_rs2, bad_idx, ok;
  logic [3:0] alu_f;
  logic [WIDTH-1:0] rd1, rd2, imm;
  logic reg_write_d, mem_write_d, branch_d, jump_d, jalr_d, alu_src_d;
  logic [1:0] result_src_d;
  logic [3:0] alu_ctrl_d;
  assign op  = instr_D[6:0];
  assign f3  = instr_D[14:12];
  assign rd  = instr_D[11:7];
  assign rs1 = instr_D[19:15];
  assign rs2 = instr_D[24:20];
  always_ff @(posedge clk)
    if (regWrite_W && Rd_W != 5'd0 && {1'b0, Rd_W} < NR) regs[Rd_W[AW-1:0]] <= result_W;
  // Write-through bypass lets W and D share a cycle without a separate forwarding path
  assign rd1 = (rs1 == 5'd0) ? '0 : (regWrite_W && Rd_W == rs1) ? result_W :
               ({1'b0, rs1} < NR) ? regs[rs1[AW-1:0]] : '0;
  assign rd2 = (rs2 == 5'd0) ? '0 : (regWrite_W && Rd_W == rs2) ? result_W :
               ({1'b0, rs2} < NR) ? regs[rs2[AW-1:0]] : '0;
  assign a0 = regs[10];
  always_comb begin
    is_r     = op == 7'b0110011;
    is_i     = op == 7'b0010011;
    is_ld    = op == 7'b0000011;
    is_st    = op == 7'b0100011;
    is_br    = op == 7'b1100011;
    is_jal   = op == 7'b1101111;
    is_jalr  = op == 7'b1100111;
    is_lui   = op == 7'b0110111;
    is_auipc = op == 7'b0010111;
    known    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
    uses_rd  = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc;
    uses_rs1 = is_r | is_i | is_ld | is_st | is_br | is_jalr;
    uses_rs2 = is_r | is_st | is_br;
    bad_idx  = (uses_rd && {1'b0, rd} >= NR) || (uses_rs1 && {1'b0, rs1} >= NR) ||
               (uses_rs2 && {1'b0, rs2} >= NR);
    ok = known && !bad_idx;
    alu_f = (f3 == 3'd0) ? ((is_r && instr_D[30]) ? SUB : ADD) :
            (f3 == 3'd1) ? SLL : (f3 == 3'd2) ? SLT : (f3 == 3'd3) ? SLTU :
            (f3 == 3'd4) ? XOR_ : (f3 == 3'd5) ? (instr_D[30] ? SRA : SRL) :
            (f3 == 3'd6) ? OR_ : AND_;
    reg_write_d  = ok && uses_rd;
    mem_write_d  = ok && is_st;
    branch_d     = ok && is_br;
    jump_d       = ok && (is_jal || is_jalr);
    jalr_d       = ok && is_jalr;
    alu_src_d    = ok && (is_i || is_ld || is_st || is_jalr || is_lui || is_auipc);
    result_src_d = !ok ? 2'b00 : is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
    alu_ctrl_d   = !ok ? ADD : (is_r || is_i) ? alu_f : is_br ? SUB : is_lui ? PASS_B : ADD;
    imm = is_st ? {{(WIDTH-12){instr_D[31]}}, instr_D[31:25], instr_D[11:7]} :
          is_br ? {{(WIDTH-12){instr_D[31]}}, instr_D[7], instr_D[30:25], instr_D[11:8], 1'b0} :
          (is_lui || is_auipc) ? {{(WIDTH-32){instr_D[31]}}, instr_D[31:12], 12'b0} :
          is_jal ? {{(WIDTH-20){instr_D[31]}}, instr_D[19:12], instr_D[20], instr_D[30:21], 1'b0} :
          {{(WIDTH-12){instr_D[31]}}, instr_D[31:20]};
  end
  // rs1 is compared unconditionally; rs2 only where the format actually reads it
  assign stall_D = valid_D && resultSrc_E == 2'b01 && Rd_E != 5'd0 &&
                   (Rd_E == rs1 || (uses_rs2 && Rd_E == rs2));
  always_ff @(posedge clk) begin
    if (rst || flush_E || stall_D || !valid_D) begin
      regWrite_E  <= 1'b0;
      memWrite_E  <= 1'b0;
      branch_E    <= 1'b0;
      jump_E      <= 1'b0;
      jalr_E      <= 1'b0;
      ALUsrc_E    <= 1'b0;
      illegal_E   <= 1'b0;
      resultSrc_E <= 2'b00;
      ALUctrl_E   <= 4'h0;
      funct3_E    <= 3'd0;
      Rs1_E       <= 5'd0;
      Rs2_E       <= 5'd0;
      Rd_E        <= 5'd0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      ImmExt_E    <= '0;
      pc_E        <= '0;
    end else begin
      regWrite_E  <= reg_write_d;
      memWrite_E  <= mem_write_d;
      branch_E    <= branch_d;
      jump_E      <= jump_d;
      jalr_E      <= jalr_d;
      ALUsrc_E    <= alu_src_d;
      illegal_E   <= !ok;
      resultSrc_E <= result_src_d;
      ALUctrl_E   <= alu_ctrl_d;
      funct3_E    <= ok ? f3 : 3'd0;
      Rs1_E       <= (ok && uses_rs1) ? rs1 : 5'd0;
      Rs2_E       <= (ok && uses_rs2) ? rs2 : 5'd0;
      Rd_E        <= reg_write_d ? rd : 5'd0;
      RD1_E       <= is_auipc ? pc_D : rd1;
      RD2_E       <= rd2;
      ImmExt_E    <= imm;
      pc_E        <= pc_D;
    end
  end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed checks of decode, bypass, load-use stall, flush, reset and illegal flagging
module tb_decode_stage_pipe;
  logic clk = 0, rst;
  logic [31:0] instr_D, pc_D, result_W;
  logic valid_D, flush_E, regWrite_W;
  logic [4:0] Rd_W;
  logic stall_D, regWrite_E, memWrite_E, branch_E, jump_E, jalr_E, ALUsrc_E, illegal_E;
  logic [1:0] resultSrc_E;
  logic [3:0] ALUctrl_E;
  logic [2:0] funct3_E;
  logic [4:0] Rs1_E, Rs2_E, Rd_E;
  logic [31:0] RD1_E, RD2_E, ImmExt_E, pc_E, a0;
  logic s16, rw16, mw16, br16, j16, jr16, as16, il16;
  logic [1:0] rs16;
  logic [3:0] ac16;
  logic [2:0] f16;
  logic [4:0] r1_16, r2_16, rd16;
  logic [31:0] d1_16, d2_16, im16, pc16, a016;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  decode_stage_pipe dut (
    .clk(clk), .rst(rst), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D), .flush_E(flush_E),
    .regWrite_W(regWrite_W), .Rd_W(Rd_W), .result_W(result_W), .stall_D(stall_D),
    .regWrite_E(regWrite_E), .memWrite_E(memWrite_E), .branch_E(branch_E), .jump_E(jump_E),
    .jalr_E(jalr_E), .ALUsrc_E(ALUsrc_E), .illegal_E(illegal_E), .resultSrc_E(resultSrc_E),
    .ALUctrl_E(ALUctrl_E), .funct3_E(funct3_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExt_E(ImmExt_E), .pc_E(pc_E), .a0(a0));

  decode_stage_pipe #(.NUM_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D), .flush_E(flush_E),
    .regWrite_W(regWrite_W), .Rd_W(Rd_W), .result_W(result_W), .stall_D(s16),
    .regWrite_E(rw16), .memWrite_E(mw16), .branch_E(br16), .jump_E(j16),
    .jalr_E(jr16), .ALUsrc_E(as16), .illegal_E(il16), .resultSrc_E(rs16),
    .ALUctrl_E(ac16), .funct3_E(f16), .Rs1_E(r1_16), .Rs2_E(r2_16), .Rd_E(rd16),
    .RD1_E(d1_16), .RD2_E(d2_16), .ImmExt_E(im16), .pc_E(pc16), .a0(a016));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    instr_D = ins;
    pc_D = pc;
    valid_D = 1;
  endtask

  initial begin
    rst = 1; flush_E = 0; regWrite_W = 0; Rd_W = 0; result_W = 0;
    drive(32'h0000A283, 32'h40);
    tick(); tick();
    chk("rst_regWrite", {31'd0, regWrite_E}, 0);
    chk("rst_resultSrc", {30'd0, resultSrc_E}, 0);
    chk("rst_Rd", {27'd0, Rd_E}, 0);
    chk("rst_pc", pc_E, 0);
    chk("rst_ImmExt", ImmExt_E, 0);
    chk("rst_stall", {31'd0, stall_D}, 0);
    rst = 0;
    drive(32'h00500513, 32'h100);
    tick();
    chk("addi_ImmExt", ImmExt_E, 5);
    chk("addi_ALUsrc", {31'd0, ALUsrc_E}, 1);
    chk("addi_Rd", {27'd0, Rd_E}, 10);
    chk("addi_regWrite", {31'd0, regWrite_E}, 1);
    chk("addi_pc", pc_E, 32'h100);
    chk("addi_RD1_x0", RD1_E, 0);
    regWrite_W = 1; Rd_W = 10; result_W = 5;
    drive(32'hFFF00093, 32'h104);
    tick();
    chk("a0_written", a0, 5);
    chk("addi_neg_ImmExt", ImmExt_E, 32'hFFFF_FFFF);
    chk("addi_neg_ALUctrl", {28'd0, ALUctrl_E}, 0);
    chk("addi_neg_ALUsrc", {31'd0, ALUsrc_E}, 1);
    Rd_W = 3; result_W = 32'hAB;
    drive(32'h00318233, 32'h108);
    tick();
    chk("bypass_RD1", RD1_E, 32'hAB);
    chk("bypass_RD2", RD2_E, 32'hAB);
    chk("add_ALUsrc", {31'd0, ALUsrc_E}, 0);
    chk("add_Rs2", {27'd0, Rs2_E}, 3);
    regWrite_W = 0;
    drive(32'h402083B3, 32'h10C);
    tick();
    chk("sub_ALUctrl", {28'd0, ALUctrl_E}, 1);
    chk("sub_Rd", {27'd0, Rd_E}, 7);
    drive(32'h0000A283, 32'h110);
    tick();
    chk("lw_resultSrc", {30'd0, resultSrc_E}, 1);
    chk("lw_funct3", {29'd0, funct3_E}, 2);
    chk("lw_Rd", {27'd0, Rd_E}, 5);
    drive(32'h00228333, 32'h114);
    #1;
    chk("loaduse_stall", {31'd0, stall_D}, 1);
    tick();
    chk("loaduse_bubble_regWrite", {31'd0, regWrite_E}, 0);
    chk("loaduse_bubble_Rd", {27'd0, Rd_E}, 0);
    chk("loaduse_stall_released", {31'd0, stall_D}, 0);
    tick();
    chk("loaduse_add_Rd", {27'd0, Rd_E}, 6);
    chk("loaduse_add_regWrite", {31'd0, regWrite_E}, 1);
    chk("loaduse_add_pc", pc_E, 32'h114);
    drive(32'h0000A283, 32'h118);
    tick();
    drive(32'h00028463, 32'h11C);
    flush_E = 1;
    #1;
    chk("flush_stall_kept", {31'd0, stall_D}, 1);
    tick();
    chk("flush_branch", {31'd0, branch_E}, 0);
    chk("flush_regWrite", {31'd0, regWrite_E}, 0);
    flush_E = 0;
    tick();
    chk("beq_branch", {31'd0, branch_E}, 1);
    chk("beq_ImmExt", ImmExt_E, 8);
    chk("beq_ALUctrl", {28'd0, ALUctrl_E}, 1);
    regWrite_W = 1; Rd_W = 0; result_W = 32'h55;
    drive(32'h00000633, 32'h120);
    tick();
    chk("x0_no_bypass", RD1_E, 0);
    regWrite_W = 0;
    drive(32'h0020A223, 32'h124);
    tick();
    chk("sw_memWrite", {31'd0, memWrite_E}, 1);
    chk("sw_ImmExt", ImmExt_E, 4);
    chk("sw_regWrite", {31'd0, regWrite_E}, 0);
    drive(32'h12345437, 32'h128);
    tick();
    chk("lui_ImmExt", ImmExt_E, 32'h1234_5000);
    chk("lui_ALUctrl", {28'd0, ALUctrl_E}, 4'hF);
    chk("lui_ALUsrc", {31'd0, ALUsrc_E}, 1);
    drive(32'hFFDFF0EF, 32'h12C);
    tick();
    chk("jal_ImmExt", ImmExt_E, 32'hFFFF_FFFC);
    chk("jal_resultSrc", {30'd0, resultSrc_E}, 2);
    chk("jal_jump", {31'd0, jump_E}, 1);
    chk("jal_jalr", {31'd0, jalr_E}, 0);
    drive(32'h00001497, 32'h200);
    tick();
    chk("auipc_ImmExt", ImmExt_E, 32'h1000);
    chk("auipc_RD1_pc", RD1_E, 32'h200);
    chk("auipc_jump", {31'd0, jump_E}, 0);
    chk("auipc_resultSrc", {30'd0, resultSrc_E}, 0);
    drive(32'h0000007F, 32'h204);
    tick();
    chk("bad_op_illegal", {31'd0, illegal_E}, 1);
    chk("bad_op_memWrite", {31'd0, memWrite_E}, 0);
    chk("bad_op_regWrite", {31'd0, regWrite_E}, 0);
    drive(32'h001088B3, 32'h208);
    tick();
    chk("rv32i_x17_illegal", {31'd0, illegal_E}, 0);
    chk("rv32i_x17_regWrite", {31'd0, regWrite_E}, 1);
    chk("rv32e_x17_illegal", {31'd0, il16}, 1);
    chk("rv32e_x17_regWrite", {31'd0, rw16}, 0);
    valid_D = 0;
    tick();
    chk("invalid_bubble", {31'd0, regWrite_E}, 0);
    chk("invalid_illegal", {31'd0, illegal_E}, 0);
    drive(32'h0000A283, 32'h300);
    tick();
    drive(32'h00228333, 32'h304);
    rst = 1;
    tick();
    chk("midrst_resultSrc", {30'd0, resultSrc_E}, 0);
    chk("midrst_Rd", {27'd0, Rd_E}, 0);
    chk("midrst_pc", pc_E, 0);
    chk("midrst_stall", {31'd0, stall_D}, 0);
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
